load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/load_store_unit_align.sv | 67 ++++++
 rtl/load_store_unit.sv | 122 ++++++++++++
 tb/tb_load_store_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane logic: enables, store replication, access legality and load lane extraction.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic            rd,
   input  logic            wr,
   input  logic [XLEN-1:0] wdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata_lane,
   output logic            fault,
   input  logic [2:0]      rsp_funct3,
   input  logic [1:0]      rsp_off,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] rdata_fmt
);

   logic                   misaligned;
   logic                   unsupported;
   logic [XLEN-1:0]        shifted;
   logic signed [7:0]      byte_s;
   logic signed [15:0]     half_s;

   always_comb begin
      be          = 4'b0000;
      wdata_lane  = '0;
      misaligned  = 1'b0;
      case (funct3[1:0])
         2'b00: begin
            be         = 4'b0001 << addr_lo;
            wdata_lane = {(XLEN/8){wdata[7:0]}};
         end
         2'b01: begin
            be         = 4'b0011 << {addr_lo[1], 1'b0};
            wdata_lane = {(XLEN/16){wdata[15:0]}};
            misaligned = addr_lo[0];
         end
         2'b10: begin
            be         = 4'b1111;
            wdata_lane = wdata;
            misaligned = |addr_lo;
         end
         default: ;
      endcase
      // Stores never use funct3[2]; loads only use it with byte/halfword sizes.
      unsupported = (funct3[1:0] == 2'b11) | (funct3[2] & (wr | funct3[1]));
      fault       = (rd & wr) | ((rd | wr) & (unsupported | misaligned));
   end

   always_comb begin
      shifted   = rdata >> {rsp_off, 3'b000};
      byte_s    = shifted[7:0];
      half_s    = shifted[15:0];
      rdata_fmt = shifted;
      case (rsp_funct3)
         F3_LB:   rdata_fmt = XLEN'(byte_s);
         F3_LH:   rdata_fmt = XLEN'(half_s);
         F3_LBU:  rdata_fmt = XLEN'(shifted[7:0]);
         F3_LHU:  rdata_fmt = XLEN'(shifted[15:0]);
         default: rdata_fmt = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store unit: one outstanding memory request, stalling the pipeline until done.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            MemReadM,
   input  logic            MemWriteM,
   input  logic [2:0]      Funct3M,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] ReadDataM,
   output logic            MemStallM,
   output logic            LsuFaultM,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic            mem_req_we,
   output logic [XLEN-1:0] mem_req_addr,
   output logic [3:0]      mem_req_be,
   output logic [XLEN-1:0] mem_req_wdata,
   input  logic            mem_rsp_valid,
   input  logic [XLEN-1:0] mem_rsp_rdata
);

   lsu_state_e             state_q, state_d;
   logic                   launch, capture;
   logic [3:0]             be_c;
   logic [XLEN-1:0]        wdata_c, rdata_c;
   logic                   fault_c;

   logic [XLEN-1:0]        addr_p1, wdata_p1, rdata_p1;
   logic [3:0]             be_p1;
   logic                   we_p1;
   logic [2:0]             funct3_p1;
   logic [1:0]             off_p1;

   lsu_align #(.XLEN(XLEN)) u_align (
      .funct3     (Funct3M),
      .addr_lo    (ALUResultM[1:0]),
      .rd         (MemReadM),
      .wr         (MemWriteM),
      .wdata      (WriteDataM),
      .be         (be_c),
      .wdata_lane (wdata_c),
      .fault      (fault_c),
      .rsp_funct3 (funct3_p1),
      .rsp_off    (off_p1),
      .rdata      (mem_rsp_rdata),
      .rdata_fmt  (rdata_c)
   );

   always_comb begin
      state_d   = state_q;
      MemStallM = 1'b0;
      LsuFaultM = 1'b0;
      launch    = 1'b0;
      capture   = 1'b0;
      case (state_q)
         IDLE: begin
            if (MemReadM | MemWriteM) begin
               if (fault_c) begin
                  LsuFaultM = 1'b1;
               end else begin
                  MemStallM = 1'b1;
                  launch    = 1'b1;
                  state_d   = REQ;
               end
            end
         end
         REQ: begin
            MemStallM = 1'b1;
            if (mem_req_ready) state_d = we_p1 ? DONE : WAIT;
         end
         WAIT: begin
            MemStallM = 1'b1;
            if (mem_rsp_valid) begin
               capture = 1'b1;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request fields are only visible while the request is presented.
   assign mem_req_valid = (state_q == REQ);
   assign mem_req_we    = mem_req_valid & we_p1;
   assign mem_req_addr  = mem_req_valid ? addr_p1 : '0;
   assign mem_req_be    = mem_req_valid ? be_p1 : 4'b0000;
   assign mem_req_wdata = mem_req_valid ? wdata_p1 : '0;
   assign ReadDataM     = (state_q == DONE) ? rdata_p1 : '0;

   // p1: registered request and captured response
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_p1   <= '0;
         wdata_p1  <= '0;
         rdata_p1  <= '0;
         be_p1     <= 4'b0000;
         we_p1     <= 1'b0;
         funct3_p1 <= 3'b000;
         off_p1    <= 2'b00;
      end else begin
         state_q <= state_d;
         if (launch) begin
            addr_p1   <= {ALUResultM[XLEN-1:2], 2'b00};
            wdata_p1  <= wdata_c;
            be_p1     <= be_c;
            we_p1     <= MemWriteM;
            funct3_p1 <= Funct3M;
            off_p1    <= ALUResultM[1:0];
            rdata_p1  <= '0;
         end
         if (capture) rdata_p1 <= rdata_c;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized accesses.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemReadM, MemWriteM;
   logic [2:0]  Funct3M;
   logic [31:0] ALUResultM, WriteDataM, ReadDataM;
   logic        MemStallM, LsuFaultM;
   logic        mem_req_valid, mem_req_ready, mem_req_we;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic [3:0]  mem_req_be;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_rdata;

   int ncmp = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   load_store_unit #(.XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
      .MemStallM(MemStallM), .LsuFaultM(LsuFaultM),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
      .mem_req_addr(mem_req_addr), .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int ref_bytes(input logic [2:0] f3);
      int m = int'(f3) % 4;
      return (m == 0) ? 1 : (m == 1) ? 2 : 4;
   endfunction

   function automatic bit ref_fault(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
      bit legal;
      if (rd && wr) return 1'b1;
      if (rd) legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      else    legal = (f3 == 0 || f3 == 1 || f3 == 2);
      if (!legal) return 1'b1;
      return (a % ref_bytes(f3)) != 0;
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
      int n = ref_bytes(f3);
      return 4'(((1 << n) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r;
      int n = ref_bytes(f3);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
      longint bits = 8 * ref_bytes(f3);
      longint v = (longint'(w) >> (8 * (a % 4))) & ((64'd1 << bits) - 1);
      if (f3 < 4 && bits < 32 && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
      return 32'(v);
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic idle_chk(input string tag);
      @(negedge clk);
      MemReadM = 0; MemWriteM = 0; mem_req_ready = 0; mem_rsp_valid = 0;
      #1;
      chk({tag, ".stall"}, 32'(MemStallM), 0);
      chk({tag, ".fault"}, 32'(LsuFaultM), 0);
      chk({tag, ".valid"}, 32'(mem_req_valid), 0);
      chk({tag, ".rdata"}, ReadDataM, 0);
      chk({tag, ".addr"},  mem_req_addr, 0);
      chk({tag, ".be"},    32'(mem_req_be), 0);
   endtask

   // One M-stage access with memory ready after rdy_dly cycles and response rsp_dly cycles after WAIT entry.
   task automatic access(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int rdy_dly,
                         input int rsp_dly, input logic [31:0] rword,
                         output logic [31:0] result, output int stalls);
      bit flt = ref_fault(rd, wr, f3, a);
      stalls = 0;
      result = 'x;
      @(negedge clk);
      MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
      mem_req_ready = 0; mem_rsp_valid = 0;
      #1;
      chk({tag, ".fault"}, 32'(LsuFaultM), 32'(flt));
      chk({tag, ".idle_valid"}, 32'(mem_req_valid), 0);
      chk({tag, ".idle_stall"}, 32'(MemStallM), 32'(!flt));
      if (flt) begin
         chk({tag, ".fault_rdata"}, ReadDataM, 0);
         result = ReadDataM;
         return;
      end
      stalls++;
      for (int k = 0; k <= rdy_dly; k++) begin
         @(negedge clk);
         mem_req_ready = (k == rdy_dly);
         mem_rsp_valid = $urandom_range(0, 1);   // must be ignored outside WAIT
         mem_rsp_rdata = $urandom;
         #1;
         chk({tag, ".req_valid"}, 32'(mem_req_valid), 1);
         chk({tag, ".req_addr"}, mem_req_addr, a - (a % 4));
         chk({tag, ".req_be"}, 32'(mem_req_be), 32'(ref_be(f3, a)));
         chk({tag, ".req_we"}, 32'(mem_req_we), 32'(wr));
         if (wr) chk({tag, ".req_wdata"}, mem_req_wdata, ref_wdata(f3, wd));
         if (MemStallM) stalls++;
      end
      if (rd) begin
         for (int j = 0; j <= rsp_dly; j++) begin
            @(negedge clk);
            mem_req_ready = 0;
            mem_rsp_valid = (j == rsp_dly);
            mem_rsp_rdata = rword;
            #1;
            chk({tag, ".wait_valid"}, 32'(mem_req_valid), 0);
            if (MemStallM) stalls++;
         end
      end
      @(negedge clk);
      mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = $urandom;
      #1;
      chk({tag, ".done_stall"}, 32'(MemStallM), 0);
      chk({tag, ".done_valid"}, 32'(mem_req_valid), 0);
      chk({tag, ".done_rdata"}, ReadDataM, rd ? ref_load(f3, a, rword) : 32'h0);
      chk({tag, ".stalls"}, 32'(stalls), 32'(2 + rdy_dly + (rd ? rsp_dly + 1 : 0)));
      result = ReadDataM;
   endtask

   initial begin
      logic [31:0] res;
      int st;
      rst = 1; MemReadM = 0; MemWriteM = 0; Funct3M = 0; ALUResultM = 0; WriteDataM = 0;
      mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 0;
      idle_chk("reset");

      // LW zero-wait
      access("lw100", 1, 0, 3'b010, 32'h100, 0, 0, 0, 32'hDEADBEEF, res, st);
      chk("lw100.value", res, 32'hDEADBEEF);
      chk("lw100.stall3", 32'(st), 3);

      // LB / LBU lane 3
      access("lb103", 1, 0, 3'b000, 32'h103, 0, 0, 0, 32'h80FFFF7F, res, st);
      chk("lb103.value", res, 32'hFFFFFF80);
      access("lbu103", 1, 0, 3'b100, 32'h103, 0, 0, 0, 32'h80FFFF7F, res, st);
      chk("lbu103.value", res, 32'h00000080);
      idle_chk("after_loads");

      // SH with ready held low three cycles
      access("sh102", 0, 1, 3'b001, 32'h102, 32'h1234ABCD, 3, 0, 0, res, st);
      chk("sh102.stall5", 32'(st), 5);
      chk("sh102.be_const", 32'(ref_be(3'b001, 32'h102)), 32'hC);

      // misaligned LW
      access("lw101", 1, 0, 3'b010, 32'h101, 0, 0, 0, 0, res, st);
      chk("lw101.valid_next", 32'(mem_req_valid), 0);
      idle_chk("after_fault");

      // reset while waiting for the response, then a late response
      @(negedge clk);
      MemReadM = 1; Funct3M = 3'b010; ALUResultM = 32'h200; #1;
      chk("rstwait.idle_stall", 32'(MemStallM), 1);
      @(negedge clk); mem_req_ready = 1; #1;
      chk("rstwait.req_valid", 32'(mem_req_valid), 1);
      @(negedge clk); mem_req_ready = 0; rst = 1; #1;
      chk("rstwait.wait_stall", 32'(MemStallM), 1);
      @(negedge clk); rst = 0; MemReadM = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h55AA55AA; #1;
      chk("rstwait.stall", 32'(MemStallM), 0);
      chk("rstwait.valid", 32'(mem_req_valid), 0);
      chk("rstwait.rdata", ReadDataM, 0);
      idle_chk("rstwait.after");

      // SW immediately followed by LW
      access("b2b_sw", 0, 1, 3'b010, 32'h40, 32'hCAFEF00D, 0, 0, 0, res, st);
      chk("b2b_sw.stall2", 32'(st), 2);
      access("b2b_lw", 1, 0, 3'b010, 32'h40, 0, 0, 0, 32'h0BADF00D, res, st);
      chk("b2b_lw.value", res, 32'h0BADF00D);
      idle_chk("b2b.no_reissue");

      // randomized accesses
      for (int n = 0; n < 60; n++) begin
         bit rd, wr;
         int sel = $urandom_range(0, 9);
         rd = (sel < 5) || (sel == 9);
         wr = (sel >= 5);
         access($sformatf("rnd%0d", n), rd, wr, 3'($urandom_range(0, 7)), $urandom,
                $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, res, st);
         if ($urandom_range(0, 2) == 0) idle_chk($sformatf("rnd%0d.idle", n));
      end
      idle_chk("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
